// File: rtl/fs_pkg.sv
// Shared definitions for the full subtractor: default sizes and a golden reference function.
// fs_ref returns {borrow, diff} in the low width+1 bits.
package fs_pkg;

    localparam int FS_WIDTH = 1;
    localparam int FS_CNT_W = 8;

    function automatic logic [32:0] fs_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic c, input int unsigned width);
        logic [32:0] full;
        logic [32:0] mask;
        full = {1'b0, a} - {1'b0, b} - {32'd0, c};
        // a-b-c lies in [-2^w, 2^w-1], so bit w of the two's complement result is the borrow
        mask = (33'd1 << (width + 1)) - 33'd1;
        return full & mask;
    endfunction

endpackage

// File: rtl/fs_if.sv
// Operand/result bundle for fs; borrow_cnt only exists when FS_BORROW_CNT_EN is defined.
// master drives operands and enable, slave (the subtractor) drives results.
interface fs_if #(
    parameter int WIDTH = fs_pkg::FS_WIDTH,
    parameter int CNT_W = fs_pkg::FS_CNT_W
) ();

    logic             en;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             vld_q;
`ifdef FS_BORROW_CNT_EN
    logic [CNT_W-1:0] borrow_cnt;

    modport master (output en, a, b, c,
                    input  diff, borrow, diff_q, borrow_q, vld_q, borrow_cnt);
    modport slave  (input  en, a, b, c,
                    output diff, borrow, diff_q, borrow_q, vld_q, borrow_cnt);
`else
    modport master (output en, a, b, c,
                    input  diff, borrow, diff_q, borrow_q, vld_q);
    modport slave  (input  en, a, b, c,
                    output diff, borrow, diff_q, borrow_q, vld_q);
`endif

endinterface

// File: rtl/fs_cell.sv
// 1-bit full subtractor cell: d = a - b - bin, bout set when the bit underflows.
// Latency: combinational. Backpressure: none.
module fs_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/fs.sv
// Ripple full subtractor diff = a - b - c with combinational and en-qualified registered results.
// Latency: diff/borrow 0 cycles, diff_q/borrow_q/vld_q 1 cycle. Backpressure: none (en gates capture).
// FS_BORROW_CNT_EN adds a saturating borrow event counter on borrow_cnt.
module fs
    import fs_pkg::*;
#(
    parameter int WIDTH = FS_WIDTH,
    parameter int CNT_W = FS_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    fs_if.slave  bus
);

    if (WIDTH < 1 || CNT_W < 1) begin : g_bad_param
        $error("fs: WIDTH and CNT_W must be >= 1");
    end

    logic [WIDTH:0]   bchain;
    logic [WIDTH-1:0] diff_w;
    logic [WIDTH-1:0] diff_r;
    logic             borrow_r;
    logic             vld_r;

    assign bchain[0] = bus.c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        fs_cell u_cell (
            .a    (bus.a[i]),
            .b    (bus.b[i]),
            .bin  (bchain[i]),
            .d    (diff_w[i]),
            .bout (bchain[i+1])
        );
    end

    assign bus.diff   = diff_w;
    assign bus.borrow = bchain[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_r   <= '0;
            borrow_r <= 1'b0;
            vld_r    <= 1'b0;
        end else begin
            vld_r <= bus.en;
            if (bus.en) begin
                diff_r   <= diff_w;
                borrow_r <= bchain[WIDTH];
            end
        end
    end

    assign bus.diff_q   = diff_r;
    assign bus.borrow_q = borrow_r;
    assign bus.vld_q    = vld_r;

`ifdef FS_BORROW_CNT_EN
    logic [CNT_W-1:0] cnt_r;

    // Saturate rather than wrap so a full counter still reads as "many borrows"
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (bus.en && bchain[WIDTH] && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    assign bus.borrow_cnt = cnt_r;
`endif

endmodule

// File: tb/tb_fs.sv
// Directed bench for fs: 1-bit truth table, registered path, async reset, 4-bit cases, 8-bit sweep.
module tb_fs;
    import fs_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   passed;

    fs_if #(.WIDTH(1))             i1 ();
    fs_if #(.WIDTH(4), .CNT_W(2)) i4 ();
    fs_if #(.WIDTH(8))             i8 ();

    fs #(.WIDTH(1))             u_w1 (.clk(clk), .rst_n(rst_n), .bus(i1));
    fs #(.WIDTH(4), .CNT_W(2)) u_w4 (.clk(clk), .rst_n(rst_n), .bus(i4));
    fs #(.WIDTH(8))             u_w8 (.clk(clk), .rst_n(rst_n), .bus(i8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else
            passed++;
    endtask

    // {borrow, diff} for abc = 0..7
    logic [1:0] tt [8] = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11};

    initial begin
        logic [2:0]  abc;
        logic [32:0] ref_v;
        logic [8:0]  exp9;
        total  = 0;
        passed = 0;
        rst_n  = 1'b0;
        {i1.en, i1.a, i1.b, i1.c} = '0;
        {i4.en, i4.a, i4.b, i4.c} = '0;
        {i8.en, i8.a, i8.b, i8.c} = '0;

        #12;
        check("rst_w1", 64'({i1.vld_q, i1.borrow_q, i1.diff_q}), 64'd0);
        check("rst_w4", 64'({i4.vld_q, i4.borrow_q, i4.diff_q}), 64'd0);
        check("rst_w8", 64'({i8.vld_q, i8.borrow_q, i8.diff_q}), 64'd0);
`ifdef FS_BORROW_CNT_EN
        check("rst_cnt", 64'(i4.borrow_cnt), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // 1-bit truth table, combinational only
        for (int v = 0; v < 8; v++) begin
            abc = 3'(v);
            {i1.a, i1.b, i1.c} = abc;
            #5;
            check($sformatf("tt_%0d", v), 64'({i1.borrow, i1.diff}), 64'(tt[v]));
        end

        // Registered capture then hold
        @(negedge clk);
        i1.en = 1'b1; i1.a = 1'b1; i1.b = 1'b0; i1.c = 1'b0;
        @(posedge clk); #1;
        check("reg_cap", 64'({i1.vld_q, i1.borrow_q, i1.diff_q}), 64'b101);
        @(negedge clk);
        i1.en = 1'b0; i1.a = 1'b0; i1.b = 1'b1;
        @(posedge clk); #1;
        check("reg_hold", 64'({i1.vld_q, i1.borrow_q, i1.diff_q}), 64'b001);

        // Async reset between edges
        @(negedge clk);
        i1.en = 1'b1; i1.a = 1'b0; i1.b = 1'b1; i1.c = 1'b0;
        @(posedge clk); #1;
        check("pre_rst", 64'({i1.vld_q, i1.borrow_q, i1.diff_q}), 64'b111);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", 64'({i1.vld_q, i1.borrow_q, i1.diff_q}), 64'd0);
        check("rst_comb", 64'({i1.borrow, i1.diff}), 64'b11);
        @(negedge clk);
        rst_n = 1'b1;
        i1.en = 1'b0;
        @(posedge clk); #1;
        check("post_rst", 64'({i1.vld_q, i1.borrow_q, i1.diff_q}), 64'd0);

        // 4-bit directed cases
        @(negedge clk);
        i4.a = 4'd3;  i4.b = 4'd5;  i4.c = 1'b1; #1;
        check("w4_3_5_1", 64'({i4.borrow, i4.diff}), 64'h1D);
        i4.a = 4'd9;  i4.b = 4'd4;  i4.c = 1'b0; #1;
        check("w4_9_4_0", 64'({i4.borrow, i4.diff}), 64'h05);
        i4.a = 4'd0;  i4.b = 4'd15; i4.c = 1'b1; #1;
        check("w4_0_f_1", 64'({i4.borrow, i4.diff}), 64'h10);
        i4.a = 4'd15; i4.b = 4'd15; i4.c = 1'b0; #1;
        check("w4_f_f_0", 64'({i4.borrow, i4.diff}), 64'h00);

`ifdef FS_BORROW_CNT_EN
        // Counter saturates at 3 with CNT_W=2
        @(negedge clk);
        i4.a = 4'd3; i4.b = 4'd5; i4.c = 1'b1; i4.en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("cnt_%0d", k), 64'(i4.borrow_cnt), 64'((k > 3) ? 3 : k));
        end
        @(negedge clk);
        i4.en = 1'b0;
`endif

        // 8-bit sweep against the reference on both paths
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            i8.en = 1'b1;
            i8.a  = 8'($urandom_range(0, 255));
            i8.b  = 8'($urandom_range(0, 255));
            i8.c  = 1'($urandom_range(0, 1));
            ref_v = fs_ref({24'd0, i8.a}, {24'd0, i8.b}, i8.c, 8);
            exp9  = ref_v[8:0];
            #1;
            check($sformatf("w8_comb_%0d", n), 64'({i8.borrow, i8.diff}), 64'(exp9));
            @(posedge clk); #1;
            check($sformatf("w8_reg_%0d", n), 64'({i8.vld_q, i8.borrow_q, i8.diff_q}),
                  64'({1'b1, exp9}));
        end
        i8.en = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
